// File: rtl/common.sv
// Shared playfield geometry and direction encoding for snake body, display and game logic.
package common_pkg;

  localparam int unsigned GAME_WIDTH    = 18;
  localparam int unsigned GAME_HEIGHT   = 13;
  localparam int unsigned SNAKE_MAX_LEN = 32;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  // Opposite directions differ only in the MSB of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body.sv
// Snake body store: circular segment buffer, move/self-collision FSM and
// a registered head-to-tail segment stream for the display.
module snake_body
  import common_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic       eat,
  input  logic       start,
  output logic [4:0] snake_head_x,
  output logic [3:0] snake_head_y,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic [5:0] length,
  output logic       failure,
  output logic       success
);

  localparam int unsigned PW = $clog2(SNAKE_MAX_LEN);

  typedef enum logic [2:0] {IDLE, STREAM, MOVE, CHECK, DEAD} state_t;

  state_t        state;
  logic [4:0]    seg_x [SNAKE_MAX_LEN];
  logic [3:0]    seg_y [SNAKE_MAX_LEN];
  logic [PW-1:0] head_ptr;
  logic [5:0]    idx;
  logic          step_pending;
  logic          pend_eat;
  dir_t          pend_dir;
  dir_t          last_dir;

  dir_t          eff_dir;
  logic [4:0]    nx;
  logic [3:0]    ny;
  logic          border;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] next_ptr;

  always_comb begin
    eff_dir  = (pend_dir == opposite(last_dir)) ? last_dir : pend_dir;
    nx       = snake_head_x;
    ny       = snake_head_y;
    unique case (eff_dir)
      DIR_RIGHT: nx = snake_head_x + 5'd1;
      DIR_DOWN:  ny = snake_head_y + 4'd1;
      DIR_LEFT:  nx = snake_head_x - 5'd1;
      DIR_UP:    ny = snake_head_y - 4'd1;
    endcase
    border   = (nx == '0) || (nx == 5'(GAME_WIDTH + 1)) ||
               (ny == '0) || (ny == 4'(GAME_HEIGHT + 1));
    // Segment k lives at head_ptr - k; idx doubles as k for stream and check.
    rd_ptr   = head_ptr - idx[PW-1:0];
    next_ptr = head_ptr + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SNAKE_MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0]               <= 5'd4;
      seg_y[0]               <= 4'd7;
      seg_x[SNAKE_MAX_LEN-1] <= 5'd3;
      seg_y[SNAKE_MAX_LEN-1] <= 4'd7;
      seg_x[SNAKE_MAX_LEN-2] <= 5'd2;
      seg_y[SNAKE_MAX_LEN-2] <= 4'd7;
      state        <= IDLE;
      head_ptr     <= '0;
      length       <= 6'd3;
      idx          <= '0;
      last_dir     <= DIR_RIGHT;
      pend_dir     <= DIR_RIGHT;
      pend_eat     <= 1'b0;
      step_pending <= 1'b0;
      failure      <= 1'b0;
      success      <= 1'b0;
      snake_valid  <= 1'b0;
      snake_first  <= 1'b0;
      snake_last   <= 1'b0;
      snake_x      <= '0;
      snake_y      <= '0;
      snake_head_x <= 5'd4;
      snake_head_y <= 4'd7;
    end else begin
      if (step && !step_pending && state != DEAD) begin
        step_pending <= 1'b1;
        pend_dir     <= dir_t'(dir);
        pend_eat     <= eat;
      end
      snake_valid <= 1'b0;
      snake_first <= 1'b0;
      snake_last  <= 1'b0;

      unique case (state)
        IDLE, DEAD: begin
          if (start) begin
            snake_valid <= 1'b1;
            snake_first <= 1'b1;
            snake_last  <= (length == 6'd1);
            snake_x     <= seg_x[head_ptr];
            snake_y     <= seg_y[head_ptr];
            idx         <= 6'd1;
            state       <= STREAM;
          end else if (state == IDLE && step_pending) begin
            state <= MOVE;
          end
        end
        STREAM: begin
          if (idx < length) begin
            snake_valid <= 1'b1;
            snake_last  <= (idx == length - 6'd1);
            snake_x     <= seg_x[rd_ptr];
            snake_y     <= seg_y[rd_ptr];
            idx         <= idx + 6'd1;
          end else begin
            state <= (failure || success) ? DEAD : IDLE;
          end
        end
        MOVE: begin
          last_dir     <= eff_dir;
          step_pending <= 1'b0;
          if (border) begin
            failure <= 1'b1;
            state   <= DEAD;
          end else begin
            // Without eat, the slot past the old tail is simply forgotten by length.
            seg_x[next_ptr] <= nx;
            seg_y[next_ptr] <= ny;
            head_ptr        <= next_ptr;
            snake_head_x    <= nx;
            snake_head_y    <= ny;
            if (pend_eat) length <= length + 6'd1;
            idx             <= 6'd1;
            state           <= CHECK;
          end
        end
        CHECK: begin
          if (idx >= length) begin
            if (length == 6'(SNAKE_MAX_LEN)) begin
              success <= 1'b1;
              state   <= DEAD;
            end else begin
              state <= IDLE;
            end
          end else if (seg_x[rd_ptr] == snake_head_x && seg_y[rd_ptr] == snake_head_y) begin
            failure <= 1'b1;
            state   <= DEAD;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: reset body, moves, growth, stream framing,
// border and self collision, win condition and reset during a stream.
module tb_snake_body;
  import common_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       eat = 1'b0;
  logic       start = 1'b0;
  logic [4:0] snake_head_x, snake_x;
  logic [3:0] snake_head_y, snake_y;
  logic       snake_first, snake_last, snake_valid, failure, success;
  logic [5:0] length;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  // Reference body: index 0 is the head.
  int   mx [SNAKE_MAX_LEN];
  int   my [SNAKE_MAX_LEN];
  int   mlen;
  dir_t mdir;
  bit   mfail, msucc;

  always #5 clk = ~clk;

  snake_body dut (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .dir          (dir),
    .eat          (eat),
    .start        (start),
    .snake_head_x (snake_head_x),
    .snake_head_y (snake_head_y),
    .snake_x      (snake_x),
    .snake_y      (snake_y),
    .snake_first  (snake_first),
    .snake_last   (snake_last),
    .snake_valid  (snake_valid),
    .length       (length),
    .failure      (failure),
    .success      (success)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx[0] = 4; my[0] = 7;
    mx[1] = 3; my[1] = 7;
    mx[2] = 2; my[2] = 7;
    mlen  = 3;
    mdir  = DIR_RIGHT;
    mfail = 1'b0;
    msucc = 1'b0;
  endtask

  task automatic model_step(input dir_t d, input bit e);
    int nx, ny;
    if (mfail || msucc) return;
    if (d != opposite(mdir)) mdir = d;
    nx = mx[0];
    ny = my[0];
    case (mdir)
      DIR_RIGHT: nx++;
      DIR_DOWN:  ny++;
      DIR_LEFT:  nx--;
      default:   ny--;
    endcase
    if (nx == 0 || nx == GAME_WIDTH + 1 || ny == 0 || ny == GAME_HEIGHT + 1) begin
      mfail = 1'b1;
      return;
    end
    if (e) mlen++;
    for (int i = mlen - 1; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = nx;
    my[0] = ny;
    for (int i = 1; i < mlen; i++)
      if (mx[i] == nx && my[i] == ny) mfail = 1'b1;
    if (!mfail && mlen == SNAKE_MAX_LEN) msucc = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; start = 1'b0; eat = 1'b0; dir = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic do_step(input dir_t d, input bit e);
    @(negedge clk);
    step = 1'b1; dir = d; eat = e;
    @(negedge clk);
    step = 1'b0; eat = 1'b0;
    repeat (SNAKE_MAX_LEN + 4) @(negedge clk);
    model_step(d, e);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_hx"}, snake_head_x, mx[0]);
    check_eq({tag, "_hy"}, snake_head_y, my[0]);
    check_eq({tag, "_len"}, length, mlen);
    check_eq({tag, "_fail"}, failure, mfail);
    check_eq({tag, "_succ"}, success, msucc);
  endtask

  task automatic check_beat(input string tag, input int k);
    check_eq({tag, "_valid"}, snake_valid, 1);
    check_eq({tag, "_x"}, snake_x, mx[k]);
    check_eq({tag, "_y"}, snake_y, my[k]);
    check_eq({tag, "_first"}, snake_first, (k == 0));
    check_eq({tag, "_last"}, snake_last, (k == mlen - 1));
  endtask

  task automatic check_stream(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < mlen; k++) begin
      check_beat($sformatf("%s_b%0d", tag, k), k);
      @(negedge clk);
    end
    check_eq({tag, "_end_valid"}, snake_valid, 0);
  endtask

  initial begin
    // Reset state and the initial body.
    apply_reset();
    check_eq("rst_valid", snake_valid, 0);
    check_eq("rst_first", snake_first, 0);
    check_eq("rst_last", snake_last, 0);
    check_eq("rst_hx", snake_head_x, 4);
    check_eq("rst_hy", snake_head_y, 7);
    check_eq("rst_len", length, 3);
    check_eq("rst_fail", failure, 0);
    check_eq("rst_succ", success, 0);
    check_stream("rst_stream");

    do_step(DIR_RIGHT, 1'b0);
    check_eq("r1_hx", snake_head_x, 5);
    check_eq("r1_len", length, 3);
    check_state("r1");
    check_stream("r1_stream");

    // Reversal is ignored; the snake keeps heading right.
    do_step(DIR_LEFT, 1'b0);
    check_eq("rev_hx", snake_head_x, 6);
    check_eq("rev_hy", snake_head_y, 7);
    check_state("rev");

    do_step(DIR_RIGHT, 1'b1);
    check_eq("eat_hx", snake_head_x, 7);
    check_eq("eat_len", length, 4);
    check_stream("eat_stream");

    // Two step pulses during a stream: first is held until the stream ends, second dropped.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < mlen; k++) begin
      step = (k == 0 || k == 2);
      dir  = (k == 0) ? DIR_DOWN : DIR_UP;
      eat  = (k == 2);
      check_beat($sformatf("sws_b%0d", k), k);
      check_eq("sws_hold_hx", snake_head_x, mx[0]);
      check_eq("sws_hold_hy", snake_head_y, my[0]);
      @(negedge clk);
    end
    step = 1'b0; eat = 1'b0;
    check_eq("sws_end_valid", snake_valid, 0);
    repeat (SNAKE_MAX_LEN + 4) @(negedge clk);
    model_step(DIR_DOWN, 1'b0);
    check_eq("sws_hx", snake_head_x, 7);
    check_eq("sws_hy", snake_head_y, 8);
    check_state("sws");

    // Run into the right border: (4,7) reaches x=18 after 14 steps, the next one hits x=19.
    apply_reset();
    for (int i = 0; i < 14; i++) do_step(DIR_RIGHT, 1'b0);
    check_eq("edge_hx", snake_head_x, 18);
    check_eq("edge_fail_pre", failure, 0);
    do_step(DIR_RIGHT, 1'b0);
    check_eq("wall_fail", failure, 1);
    check_eq("wall_hx", snake_head_x, 18);
    check_eq("wall_succ", success, 0);
    do_step(DIR_DOWN, 1'b0);
    check_state("dead_step");
    check_stream("dead_stream");
    do_step(DIR_UP, 1'b1);
    check_eq("dead2_hy", snake_head_y, 7);
    check_eq("dead2_len", length, 3);
    check_eq("dead2_fail", failure, 1);

    // Grow to 5, then curl back into the body.
    apply_reset();
    do_step(DIR_RIGHT, 1'b1);
    check_eq("grow_len", length, 4);
    check_stream("grow_stream");
    do_step(DIR_RIGHT, 1'b1);
    do_step(DIR_DOWN, 1'b0);
    do_step(DIR_LEFT, 1'b0);
    check_eq("curl_fail_pre", failure, 0);
    do_step(DIR_UP, 1'b0);
    check_eq("bite_fail", failure, 1);
    check_eq("bite_succ", success, 0);
    check_eq("bite_hx", snake_head_x, 5);
    check_eq("bite_hy", snake_head_y, 7);
    check_state("bite");

    // Serpentine growth to full length wins the game.
    apply_reset();
    for (int i = 0; i < 14; i++) do_step(DIR_RIGHT, 1'b1);
    do_step(DIR_DOWN, 1'b1);
    for (int i = 0; i < 13; i++) do_step(DIR_LEFT, 1'b1);
    check_eq("pre_win_succ", success, 0);
    check_eq("pre_win_len", length, 31);
    do_step(DIR_LEFT, 1'b1);
    check_eq("win_len", length, 32);
    check_eq("win_succ", success, 1);
    check_eq("win_fail", failure, 0);
    check_eq("win_hx", snake_head_x, 4);
    check_eq("win_hy", snake_head_y, 8);
    check_state("win");

    // Reset in the middle of a stream cuts it off at once.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_beat("abort_b0", 0);
    @(negedge clk);
    check_beat("abort_b1", 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_valid", snake_valid, 0);
    check_eq("abort_first", snake_first, 0);
    check_eq("abort_last", snake_last, 0);
    @(negedge clk);
    check_eq("abort_hold_valid", snake_valid, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("abort_len", length, 3);
    check_eq("abort_succ", success, 0);
    check_state("abort");
    check_stream("abort_stream");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
